// File: rtl/cpu_mc_pkg.sv
// cpu_mc_pkg: shared constants for the multi-cycle CPU.
//   Opcodes (IR[15:12]), ALU func codes (IR[2:0]), FSM state enum and the
//   immediate width used for sign extension.
// Instruction fields: rs = IR[11:9], rt = IR[8:6], rd = IR[5:3],
//   func = IR[2:0], imm6 = IR[5:0], jump target = IR[8:0].
package cpu_mc_pkg;

    localparam int IMM_W = 6;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_JMP   = 4'b0001;
    localparam logic [3:0] OP_LB    = 4'b0010;
    localparam logic [3:0] OP_SB    = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ANDI  = 4'b0110;
    localparam logic [3:0] OP_ORI   = 4'b0111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_BNE   = 4'b1001;
    localparam logic [3:0] OP_BGEZ  = 4'b1010;
    localparam logic [3:0] OP_BLTZ  = 4'b1011;
    localparam logic [3:0] OP_CALL  = 4'b1100;
    localparam logic [3:0] OP_RET   = 4'b1101;

    localparam logic [2:0] F_ADD   = 3'b000;
    localparam logic [2:0] F_SUB   = 3'b001;
    localparam logic [2:0] F_PASSA = 3'b010;
    localparam logic [2:0] F_XOR   = 3'b011;
    localparam logic [2:0] F_SHL1  = 3'b100;
    localparam logic [2:0] F_AND   = 3'b101;
    localparam logic [2:0] F_OR    = 3'b110;
    localparam logic [2:0] F_SHR1  = 3'b111;
    // R-type func 001 is decoded as HALT before the ALU sees it.
    localparam logic [2:0] F_HALT  = 3'b001;

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

endpackage

// File: rtl/cpu_mc_regfile.sv
// cpu_mc_regfile: NREG x DW register file.
//   CLK, RESET      : clock, synchronous active-high clear of all registers
//   RA1/RD1, RA2/RD2: asynchronous read ports (r0 always reads 0)
//   WA, WD, WE      : synchronous write port (writes to r0 are dropped)
module cpu_mc_regfile #(
    parameter int DW   = 8,
    parameter int NREG = 8,
    localparam int RW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [RW-1:0] RA1,
    input  logic [RW-1:0] RA2,
    input  logic [RW-1:0] WA,
    input  logic          WE,
    input  logic [DW-1:0] WD,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (WE && (WA != '0)) begin
            regs[WA] <= WD;
        end
    end

    assign RD1 = (RA1 == '0) ? '0 : regs[RA1];
    assign RD2 = (RA2 == '0) ? '0 : regs[RA2];

endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle 16-bit-instruction CPU with handshaked fetch and data.
//   CLK, RESET         : clock, synchronous active-high reset
//   EN_L               : active-low resume; a sampled 1->0 edge leaves HALT
//   I_REQ/I_ADDR       : fetch request and address (= PC)
//   I_VALID/Iin        : instruction return
//   D_REQ/D_WE/D_ADDR/D_WDATA : data request (D_WE=1 store)
//   D_RDATA/D_ACK      : data return / transfer complete
//   PC, HALTED         : current PC, core is in HALT
//   STK_ERR            : sticky RET-on-empty flag (only with CPU_CALL_EN)
// Build option: define CPU_CALL_EN to add CALL/RET and a 4-deep return stack.
// PW must exceed the immediate width (PW >= 7).
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int DW   = 8,
    parameter int PW   = 10,
    parameter int NREG = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          EN_L,
    output logic          I_REQ,
    output logic [PW-1:0] I_ADDR,
    input  logic          I_VALID,
    input  logic [15:0]   Iin,
    output logic          D_REQ,
    output logic          D_WE,
    output logic [PW-1:0] D_ADDR,
    output logic [DW-1:0] D_WDATA,
    input  logic [DW-1:0] D_RDATA,
    input  logic          D_ACK,
    output logic [PW-1:0] PC,
    output logic          HALTED
`ifdef CPU_CALL_EN
    ,
    output logic          STK_ERR
`endif
);

    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

    state_t        state, stateNext;
    logic [PW-1:0] pc, pcNext;
    logic [15:0]   ir;
    logic          prevEnL;

    // decode
    logic [3:0]    op;
    logic [2:0]    func;
    logic [RW-1:0] rsA, rtA, rdA;
    logic [DW-1:0] rsVal, rtVal, immD, diff;
    logic [PW-1:0] immP, pcPlus2, brTgt, jmpTgt;
    logic [9:0]    jRaw;

    assign op      = ir[15:12];
    assign func    = ir[2:0];
    assign rsA     = ir[9 +: RW];
    assign rtA     = ir[6 +: RW];
    assign rdA     = ir[3 +: RW];
    assign immD    = {{(DW-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    assign immP    = {{(PW-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    assign pcPlus2 = pc + PW'(2);
    assign brTgt   = pcPlus2 + (immP << 1);
    assign jRaw    = {ir[8:0], 1'b0};
    assign jmpTgt  = PW'(jRaw);
    assign diff    = rsVal - rtVal;

    // register file
    logic          rfWe;
    logic [RW-1:0] rfWa;
    logic [DW-1:0] rfWd;

    cpu_mc_regfile #(.DW(DW), .NREG(NREG)) uRf (
        .CLK  (CLK),
        .RESET(RESET),
        .RA1  (rsA),
        .RA2  (rtA),
        .WA   (rfWa),
        .WE   (rfWe),
        .WD   (rfWd),
        .RD1  (rsVal),
        .RD2  (rtVal)
    );

    // ALU: I-types reuse the R-type datapath with a forced func
    logic [2:0]    aluF;
    logic [DW-1:0] aluB, aluY;

    always_comb begin
        aluB = (op == OP_RTYPE) ? rtVal : immD;
        case (op)
            OP_ADDI: aluF = F_ADD;
            OP_ANDI: aluF = F_AND;
            OP_ORI:  aluF = F_OR;
            default: aluF = func;
        endcase
        case (aluF)
            F_ADD:   aluY = rsVal + aluB;
            F_SUB:   aluY = rsVal - aluB;
            F_PASSA: aluY = rsVal;
            F_XOR:   aluY = rsVal ^ aluB;
            F_SHL1:  aluY = rsVal << 1;
            F_AND:   aluY = rsVal & aluB;
            F_OR:    aluY = rsVal | aluB;
            F_SHR1:  aluY = rsVal >> 1;
            default: aluY = rsVal;
        endcase
    end

`ifdef CPU_CALL_EN
    // circular return stack: a push when full overwrites the oldest entry
    localparam int RSD = 4;
    localparam int SPW = $clog2(RSD);

    logic [PW-1:0] rstk [RSD];
    logic [SPW-1:0] sp;
    logic [SPW:0]   cnt;
    logic           stkErr, push, pop, stkEmpty;
    logic [PW-1:0]  stkTop;

    assign stkEmpty = (cnt == '0);
    assign stkTop   = rstk[sp - 1'b1];
    assign STK_ERR  = stkErr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sp     <= '0;
            cnt    <= '0;
            stkErr <= 1'b0;
            for (int i = 0; i < RSD; i++) rstk[i] <= '0;
        end else if (push) begin
            rstk[sp] <= pcPlus2;
            sp       <= sp + 1'b1;
            if (cnt != (SPW+1)'(RSD)) cnt <= cnt + 1'b1;
        end else if (pop) begin
            if (stkEmpty) begin
                stkErr <= 1'b1;
            end else begin
                sp  <= sp - 1'b1;
                cnt <= cnt - 1'b1;
            end
        end
    end
`endif

    // next state / datapath control
    always_comb begin
        stateNext = state;
        pcNext    = pc;
        rfWe      = 1'b0;
        rfWa      = rtA;
        rfWd      = aluY;
`ifdef CPU_CALL_EN
        push      = 1'b0;
        pop       = 1'b0;
`endif
        case (state)
            FETCH: if (I_VALID) stateNext = EXEC;
            EXEC: begin
                stateNext = FETCH;
                pcNext    = pcPlus2;
                case (op)
                    OP_RTYPE: begin
                        if (func == F_HALT) begin
                            stateNext = HALT;
                            pcNext    = pc;
                        end else begin
                            rfWe = 1'b1;
                            rfWa = rdA;
                        end
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: rfWe = 1'b1;
                    OP_LB, OP_SB: begin
                        stateNext = MEM;
                        pcNext    = pc;
                    end
                    OP_JMP:  pcNext = jmpTgt;
                    OP_BEQ:  if (diff == '0) pcNext = brTgt;
                    OP_BNE:  if (diff != '0) pcNext = brTgt;
                    OP_BLTZ: if (rsVal[DW-1]) pcNext = brTgt;
                    OP_BGEZ: if (!rsVal[DW-1]) pcNext = brTgt;
`ifdef CPU_CALL_EN
                    OP_CALL: begin
                        push   = 1'b1;
                        pcNext = jmpTgt;
                    end
                    OP_RET: begin
                        pop    = 1'b1;
                        pcNext = stkEmpty ? '0 : stkTop;
                    end
`else
                    OP_CALL, OP_RET: ;
`endif
                    default: ;
                endcase
            end
            MEM: begin
                if (D_ACK) begin
                    stateNext = FETCH;
                    pcNext    = pcPlus2;
                    if (op == OP_LB) begin
                        rfWe = 1'b1;
                        rfWd = D_RDATA;
                    end
                end
            end
            HALT: begin
                if (prevEnL && !EN_L) begin
                    stateNext = FETCH;
                    pcNext    = pcPlus2;
                end
            end
            default: stateNext = FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= FETCH;
            pc      <= '0;
            ir      <= '0;
            prevEnL <= 1'b1;
        end else begin
            state   <= stateNext;
            pc      <= pcNext;
            prevEnL <= EN_L;
            if (state == FETCH && I_VALID) ir <= Iin;
        end
    end

    // Moore request outputs; IR and registers are frozen in MEM so the
    // address and store data stay stable until D_ACK.
    assign I_REQ   = (state == FETCH) && !RESET;
    assign I_ADDR  = pc;
    assign D_REQ   = (state == MEM) && !RESET;
    assign D_WE    = (state == MEM) && !RESET && (op == OP_SB);
    assign D_ADDR  = PW'(rsVal) + immP;
    assign D_WDATA = rtVal;
    assign PC      = pc;
    assign HALTED  = (state == HALT);

endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: directed-vector bench for cpu_mc (DW=8, PW=10, NREG=8).
// A ROM model answers fetches, a RAM model answers data requests after a
// programmable number of wait cycles and records every accepted store.
module tb_cpu_mc;

    localparam int DW = 8;
    localparam int PW = 10;

    logic          CLK, RESET, EN_L;
    logic          I_REQ, I_VALID;
    logic [PW-1:0] I_ADDR, D_ADDR, PC;
    logic [15:0]   Iin;
    logic          D_REQ, D_WE, D_ACK, HALTED;
    logic [DW-1:0] D_WDATA, D_RDATA;
`ifdef CPU_CALL_EN
    logic          STK_ERR;
`endif

    cpu_mc #(.DW(DW), .PW(PW), .NREG(8)) dut (
        .CLK(CLK), .RESET(RESET), .EN_L(EN_L),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_VALID(I_VALID), .Iin(Iin),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_RDATA(D_RDATA), .D_ACK(D_ACK), .PC(PC), .HALTED(HALTED)
`ifdef CPU_CALL_EN
        , .STK_ERR(STK_ERR)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [15:0] rom  [512];
    logic [7:0]  dmem [1024];
    logic        ivalid;
    int          ackDly, waitCnt, nSt, lastA, lastD;
    int          nCmp, nErr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rs,
                                          input logic [2:0] rt, input logic [5:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [15:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                          input logic [2:0] rd, input logic [2:0] fn);
        return {4'b0000, rs, rt, rd, fn};
    endfunction

    function automatic logic [15:0] enc_j(input logic [3:0] op, input logic [8:0] a);
        return {op, 3'b000, a};
    endfunction

    // drive memory-side inputs for the cycle that follows an edge
    task automatic drive();
        Iin     = rom[I_ADDR[PW-1:1]];
        I_VALID = ivalid;
        D_ACK   = 1'b0;
        if (D_REQ) begin
            if (waitCnt >= ackDly) begin
                D_ACK   = 1'b1;
                waitCnt = 0;
                if (D_WE) begin
                    dmem[D_ADDR] = D_WDATA;
                    lastA = int'(D_ADDR);
                    lastD = int'(D_WDATA);
                    nSt++;
                end else begin
                    D_RDATA = dmem[D_ADDR];
                end
            end else begin
                waitCnt++;
            end
        end else begin
            waitCnt = 0;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        drive();
    endtask

    task automatic clr_rom();
        for (int i = 0; i < 512; i++) rom[i] = 16'h3000;  // unused opcode: NOP
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        step();
        chk("rst_ireq", I_REQ, 0);
        chk("rst_dreq", D_REQ, 0);
        chk("rst_pc", PC, 0);
        chk("rst_halted", HALTED, 0);
`ifdef CPU_CALL_EN
        chk("rst_stkerr", STK_ERR, 0);
`endif
        RESET = 1'b0;
        #1;
        drive();
    endtask

    task automatic expect_store(input string tag, input int a, input int d);
        int n0;
        int k;
        n0 = nSt;
        k  = 0;
        while (nSt == n0 && k < 40) begin
            step();
            k++;
        end
        chk({tag, "_seen"}, nSt - n0, 1);
        chk({tag, "_addr"}, lastA, a);
        chk({tag, "_data"}, lastD, d);
    endtask

    task automatic load_prog_a();
        clr_rom();
        rom[0]  = enc_i(4'd5, 3'd0, 3'd1, 6'd5);     // ADDI r1,r0,5
        rom[1]  = enc_i(4'd5, 3'd0, 3'd2, 6'h3D);    // ADDI r2,r0,-3
        rom[2]  = enc_r(3'd1, 3'd2, 3'd3, 3'd0);     // ADD  r3=r1+r2 = 2
        rom[3]  = enc_i(4'd4, 3'd0, 3'd3, 6'd20);    // SB r3,[20]
        rom[4]  = enc_i(4'd4, 3'd0, 3'd1, 6'd10);    // SB r1,[10]
        rom[5]  = enc_i(4'd2, 3'd0, 3'd4, 6'd10);    // LB r4,[10]
        rom[6]  = enc_i(4'd4, 3'd0, 3'd4, 6'd11);    // SB r4,[11]
        rom[7]  = enc_i(4'd6, 3'd1, 3'd5, 6'd6);     // ANDI r5=5&6 = 4
        rom[8]  = enc_i(4'd7, 3'd5, 3'd6, 6'h38);    // ORI  r6=4|F8 = FC
        rom[9]  = enc_r(3'd6, 3'd1, 3'd7, 3'd3);     // XOR  r7=FC^05 = F9
        rom[10] = enc_r(3'd7, 3'd0, 3'd5, 3'd4);     // SHL1 r5=F2
        rom[11] = enc_r(3'd7, 3'd0, 3'd6, 3'd7);     // SHR1 r6=7C
        rom[12] = enc_i(4'd4, 3'd0, 3'd5, 6'd12);    // SB r5,[12]
        rom[13] = enc_i(4'd4, 3'd0, 3'd6, 6'd13);    // SB r6,[13]
        rom[14] = enc_i(4'd5, 3'd1, 3'd0, 6'd9);     // ADDI r0 (dropped)
        rom[15] = enc_i(4'd4, 3'd1, 3'd0, 6'd2);     // SB r0,[r1+2]=[7]
        rom[16] = enc_r(3'd1, 3'd2, 3'd3, 3'd6);     // OR   r3=05|FD = FD
        rom[17] = enc_i(4'd4, 3'd1, 3'd3, 6'h3F);    // SB r3,[r1-1]=[4]
        rom[18] = enc_r(3'd7, 3'd0, 3'd4, 3'd2);     // PASSA r4=F9
        rom[19] = enc_i(4'd4, 3'd0, 3'd4, 6'd14);    // SB r4,[14]
        rom[20] = enc_r(3'd6, 3'd3, 3'd4, 3'd5);     // AND  r4=7C&FD = 7C
        rom[21] = enc_i(4'd4, 3'd0, 3'd4, 6'd15);    // SB r4,[15]
    endtask

    int brExp [12] = '{2, 4, 8, 6, 8, 10, 12, 14, 18, 20, 1022, 4};
`ifdef CPU_CALL_EN
    int clExp [10] = '{8, 16, 24, 32, 40, 34, 26, 18, 10, 0};
`endif

    initial begin
        RESET = 1'b1; EN_L = 1'b1; ivalid = 1'b1; I_VALID = 1'b0;
        Iin = '0; D_ACK = 1'b0; D_RDATA = '0;
        ackDly = 0; waitCnt = 0; nSt = 0; lastA = -1; lastD = -1;
        nCmp = 0; nErr = 0;
        for (int i = 0; i < 1024; i++) dmem[i] = 8'h00;

        // back-to-back ALU ops, 2 cycles each
        load_prog_a();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i % 2 == 0) chk($sformatf("pcA_%0d", i), PC, i);
        end

        // fetch stall on the second instruction
        do_reset();
        step();
        ivalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall_iaddr%0d", i), I_ADDR, 2);
            chk($sformatf("stall_ireq%0d", i), I_REQ, 1);
        end
        ivalid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("stall_pc6", PC, 6);
        expect_store("st20", 20, 2);

        // store with two wait cycles: request held stable
        ackDly = 2;
        step();
        chk("sb_pc8", PC, 8);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("sbw_req%0d", i), D_REQ, 1);
            chk($sformatf("sbw_we%0d", i), D_WE, 1);
            chk($sformatf("sbw_addr%0d", i), D_ADDR, 10);
            chk($sformatf("sbw_wdata%0d", i), D_WDATA, 5);
        end
        step();
        chk("sb_pc10", PC, 10);
        expect_store("lb_sb", 11, 5);
        ackDly = 0;
        expect_store("shl", 12, 8'hF2);
        expect_store("shr", 13, 8'h7C);
        expect_store("r0", 7, 0);
        expect_store("or", 4, 8'hFD);
        expect_store("passa", 14, 8'hF9);
        expect_store("and", 15, 8'h7C);

        // branches, jump and PC wrap
        clr_rom();
        rom[0]   = enc_i(4'd5, 3'd0, 3'd1, 6'd1);    // ADDI r1,r0,1
        rom[1]   = enc_i(4'd5, 3'd0, 3'd2, 6'd2);    // ADDI r2,r0,2
        rom[2]   = enc_j(4'd1, 9'd4);                // JMP 8
        rom[3]   = enc_i(4'd5, 3'd0, 3'd2, 6'd1);    // ADDI r2,r0,1
        rom[4]   = enc_i(4'd9, 3'd1, 3'd2, 6'h3E);   // BNE r1,r2,-2
        rom[5]   = enc_i(4'd8, 3'd1, 3'd0, 6'd3);    // BEQ r1,r0,+3
        rom[6]   = enc_i(4'd5, 3'd0, 3'd3, 6'h3F);   // ADDI r3,r0,-1
        rom[7]   = enc_i(4'd11, 3'd3, 3'd0, 6'd1);   // BLTZ r3,+1
        rom[8]   = enc_j(4'd1, 9'd0);                // JMP 0
        rom[9]   = enc_i(4'd10, 3'd3, 3'd0, 6'd1);   // BGEZ r3,+1
        rom[10]  = enc_j(4'd1, 9'h1FF);              // JMP 1022
        rom[511] = enc_i(4'd8, 3'd0, 3'd0, 6'd2);    // BEQ r0,r0,+2
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step();
            step();
            chk($sformatf("br_%0d", i), PC, brExp[i]);
        end

        // HALT entered with EN_L already low, resume on a fresh fall
        clr_rom();
        rom[0] = enc_i(4'd5, 3'd0, 3'd1, 6'd7);      // ADDI r1,r0,7
        rom[1] = enc_r(3'd0, 3'd0, 3'd0, 3'd1);      // HALT
        rom[2] = enc_i(4'd4, 3'd0, 3'd1, 6'd30);     // SB r1,[30]
        EN_L = 1'b0;
        do_reset();
        step(); step(); step();
        chk("halt_pre", HALTED, 0);
        step();
        chk("halt_up", HALTED, 1);
        chk("halt_pc", PC, 2);
        for (int i = 0; i < 3; i++) step();
        chk("halt_stay", HALTED, 1);
        chk("halt_pcfrz", PC, 2);
        EN_L = 1'b1;
        step(); step();
        chk("halt_enhi", HALTED, 1);
        EN_L = 1'b0;
        step();
        chk("halt_down", HALTED, 0);
        chk("halt_resume_pc", PC, 4);
        expect_store("halt_st", 30, 7);

        // reset while a data transaction is outstanding
        load_prog_a();
        ackDly = 100;
        do_reset();
        for (int k = 0; k < 20 && !D_REQ; k++) step();
        chk("rmem_dreq", D_REQ, 1);
        chk("rmem_addr", D_ADDR, 20);
        RESET = 1'b1;
        step();
        chk("rmem_dreq0", D_REQ, 0);
        chk("rmem_ireq0", I_REQ, 0);
        chk("rmem_pc0", PC, 0);
        RESET = 1'b0;
        ackDly = 0;
        #1;
        drive();
        chk("rmem_ireq1", I_REQ, 1);
        step(); step();
        chk("rmem_pc2", PC, 2);

`ifdef CPU_CALL_EN
        // five nested CALLs overflow the 4-deep stack, then RETs
        clr_rom();
        rom[0]  = enc_j(4'd12, 9'd4);
        rom[4]  = enc_j(4'd12, 9'd8);
        rom[8]  = enc_j(4'd12, 9'd12);
        rom[12] = enc_j(4'd12, 9'd16);
        rom[16] = enc_j(4'd12, 9'd20);
        rom[20] = 16'hD000;
        rom[17] = 16'hD000;
        rom[13] = 16'hD000;
        rom[9]  = 16'hD000;
        rom[5]  = 16'hD000;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            step();
            chk($sformatf("call_%0d", i), PC, clExp[i]);
            if (i == 8) chk("stkerr_lo", STK_ERR, 0);
        end
        chk("stkerr_hi", STK_ERR, 1);
`else
        // without the return stack CALL and RET are NOPs
        clr_rom();
        rom[0] = enc_j(4'd12, 9'd4);
        rom[1] = 16'hD000;
        do_reset();
        step(); step();
        chk("call_nop", PC, 2);
        step(); step();
        chk("ret_nop", PC, 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
